// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus_timer peripheral: register offsets, CTRL bit
// positions, reset values and a byte-lane merge helper.
package bus_timer_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PRESCALE = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_COMPARE  = 5'h0C;
  localparam logic [4:0] OFF_CAPTURE  = 5'h10;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_MATCH       = 8;
  localparam int CTRL_CAP         = 9;

  localparam logic [31:0] RST_COUNT   = 32'h0000_0000;
  localparam logic [31:0] RST_COMPARE = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_CAPTURE = 32'h0000_0000;

  // Replace the byte lanes of old_v selected by be with the matching lanes of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: issues one tick every (i_prescale + 1) enabled clocks.
// i_clear restarts the divide chain; a disabled prescaler holds its count.
module bus_timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [31:0] i_prescale,
  input  logic        i_clear,
  output logic        o_tick
);

  logic [31:0] r_pre_cnt;

  assign o_tick = i_en && (r_pre_cnt == i_prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= 32'd0;
    end else if (i_clear) begin
      r_pre_cnt <= 32'd0;
    end else if (i_en) begin
      r_pre_cnt <= o_tick ? 32'd0 : r_pre_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match and level irq.
// Optional capture input enabled by defining BUS_TIMER_CAPTURE_EN.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter logic [31:0] RESET_PRESCALE = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_re,
  input  logic [3:0]  bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
`ifdef BUS_TIMER_CAPTURE_EN
  ,
  input  logic        cap_in
`endif
);

  logic        r_en, r_auto, r_irq_en, r_match, r_irq;
  logic [31:0] r_prescale, r_count, r_compare;

  logic        w_hit, w_wr, w_tick, w_cnt_eq, w_match_set;
  logic        w_sel_ctrl, w_sel_pre, w_sel_cnt, w_sel_cmp, w_sel_cap;
  logic [31:0] w_count_tick, w_ctrl_rd, w_rd;
  logic        w_cap;
  logic [31:0] w_capture;

  assign w_hit = (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign w_wr  = (|bus_we) & w_hit;

  // Register select; the two low address bits are don't-care.
  always_comb begin
    w_sel_ctrl = 1'b0;
    w_sel_pre  = 1'b0;
    w_sel_cnt  = 1'b0;
    w_sel_cmp  = 1'b0;
    w_sel_cap  = 1'b0;
    casez (bus_addr[4:0])
      {OFF_CTRL[4:2],     2'b??}: w_sel_ctrl = 1'b1;
      {OFF_PRESCALE[4:2], 2'b??}: w_sel_pre  = 1'b1;
      {OFF_COUNT[4:2],    2'b??}: w_sel_cnt  = 1'b1;
      {OFF_COMPARE[4:2],  2'b??}: w_sel_cmp  = 1'b1;
      {OFF_CAPTURE[4:2],  2'b??}: w_sel_cap  = 1'b1;
      default: ;
    endcase
  end

  bus_timer_prescaler u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_en),
    .i_prescale (r_prescale),
    .i_clear    (w_wr & w_sel_pre),
    .o_tick     (w_tick)
  );

  assign w_cnt_eq     = (r_count == r_compare);
  assign w_match_set  = w_tick & w_cnt_eq;
  assign w_count_tick = !w_tick ? r_count :
                        (w_cnt_eq && r_auto) ? 32'd0 : r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_match    <= 1'b0;
      r_irq      <= 1'b0;
      r_prescale <= RESET_PRESCALE;
      r_count    <= RST_COUNT;
      r_compare  <= RST_COMPARE;
    end else begin
      // Bus-written COUNT bytes override the tick result lane by lane.
      r_count <= (w_wr && w_sel_cnt) ? merge_bytes(w_count_tick, bus_wdata, bus_we)
                                     : w_count_tick;
      if (w_wr && w_sel_pre) r_prescale <= merge_bytes(r_prescale, bus_wdata, bus_we);
      if (w_wr && w_sel_cmp) r_compare  <= merge_bytes(r_compare, bus_wdata, bus_we);
      if (w_wr && w_sel_ctrl && bus_we[0]) begin
        r_en     <= bus_wdata[CTRL_EN];
        r_auto   <= bus_wdata[CTRL_AUTO_RELOAD];
        r_irq_en <= bus_wdata[CTRL_IRQ_EN];
      end
      if (w_match_set)
        r_match <= 1'b1;
      else if (w_wr && w_sel_ctrl && bus_we[1] && bus_wdata[CTRL_MATCH])
        r_match <= 1'b0;
      r_irq <= r_match & r_irq_en;
    end
  end

`ifdef BUS_TIMER_CAPTURE_EN
  logic        r_cap_s1, r_cap_s2, r_cap_s3, r_cap;
  logic [31:0] r_capture;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_s1  <= 1'b0;
      r_cap_s2  <= 1'b0;
      r_cap_s3  <= 1'b0;
      r_cap     <= 1'b0;
      r_capture <= RST_CAPTURE;
    end else begin
      r_cap_s1 <= cap_in;
      r_cap_s2 <= r_cap_s1;
      r_cap_s3 <= r_cap_s2;
      if (r_cap_s2 && !r_cap_s3) begin
        r_cap     <= 1'b1;
        r_capture <= r_count;
      end else if (w_wr && w_sel_ctrl && bus_we[1] && bus_wdata[CTRL_CAP]) begin
        r_cap <= 1'b0;
      end
    end
  end

  assign w_cap     = r_cap;
  assign w_capture = r_capture;
`else
  assign w_cap     = 1'b0;
  assign w_capture = 32'd0;
`endif

  always_comb begin
    w_ctrl_rd                   = 32'd0;
    w_ctrl_rd[CTRL_EN]          = r_en;
    w_ctrl_rd[CTRL_AUTO_RELOAD] = r_auto;
    w_ctrl_rd[CTRL_IRQ_EN]      = r_irq_en;
    w_ctrl_rd[CTRL_MATCH]       = r_match;
    w_ctrl_rd[CTRL_CAP]         = w_cap;
  end

  always_comb begin
    w_rd = 32'd0;
    if (bus_re && w_hit) begin
      if (w_sel_ctrl) w_rd = w_ctrl_rd;
      if (w_sel_pre)  w_rd = r_prescale;
      if (w_sel_cnt)  w_rd = r_count;
      if (w_sel_cmp)  w_rd = r_compare;
      if (w_sel_cap)  w_rd = w_capture;
    end
  end

  assign bus_rdata = w_rd;
  assign irq       = r_irq;

endmodule
